// File: rtl/bcd_time_display_scan.sv
// bcd_time_display_scan: 12-hour BCD time to 6-digit multiplexed 7-segment scan.
// Optional macro HOUR_LZB_EN: blank the hours tens digit when it is zero.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high
//   disp_en  in   1: display lit; 0: anodes off, scanning continues
//   pm       in   1 = PM
//   hh       in   [7:0] BCD hours   {tens,units}, legal 01..12
//   mm       in   [7:0] BCD minutes {tens,units}, legal 00..59
//   ss       in   [7:0] BCD seconds {tens,units}, legal 00..59
//   seg      out  [6:0] segments {g,f,e,d,c,b,a}
//   dp       out  decimal point of the lit digit
//   an       out  [5:0] one-hot digit enable, an[i] = digit i
//   bcd_err  out  sticky malformed-BCD flag, cleared only by reset
//
// Parameters:
//   SCAN_DIV        clk cycles each digit is lit (>= 2)
//   SEG_ACTIVE_LOW  1: seg/dp/an active-low, 0: active-high

module bcd_time_display_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       disp_en,
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       bcd_err
);

    localparam int            PW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    // Polarity masks: XOR turns the internal active-high value into pin level.
    localparam logic [6:0] SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [5:0] AN_INV  = {6{SEG_ACTIVE_LOW}};
    localparam logic       DP_INV  = SEG_ACTIVE_LOW;

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic          load_pending;
    logic          sh_pm;
    logic [7:0]    sh_hh;
    logic [7:0]    sh_mm;
    logic [7:0]    sh_ss;

    logic       tick;
    logic       snap;
    logic       in_err;
    logic [3:0] nib;
    logic       dp_c;
    logic [6:0] seg_c;
    logic [5:0] an_c;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign tick = (prescaler == PMAX);

    // Sample inputs only at the end of a frame so a frame is never torn.
    assign snap = (tick && idx == 3'd5) || load_pending;

    // Check the values about to be captured, not the current shadow.
    always_comb begin
        in_err = 1'b0;
        if (hh[7:4] > 4'd9 || hh[3:0] > 4'd9) in_err = 1'b1;
        if (mm[7:4] > 4'd5 || mm[3:0] > 4'd9) in_err = 1'b1;
        if (ss[7:4] > 4'd5 || ss[3:0] > 4'd9) in_err = 1'b1;
        if (hh == 8'h00 || hh > 8'h12)        in_err = 1'b1;
    end

    always_comb begin
        nib  = 4'd0;
        dp_c = 1'b0;
        case (idx)
            3'd0: begin
                nib  = sh_ss[3:0];
                dp_c = sh_pm;
            end
            3'd1: nib = sh_ss[7:4];
            3'd2: begin
                nib  = sh_mm[3:0];
                dp_c = 1'b1;
            end
            3'd3: nib = sh_mm[7:4];
            3'd4: begin
                nib  = sh_hh[3:0];
                dp_c = 1'b1;
            end
            3'd5: nib = sh_hh[7:4];
            default: begin
                nib  = 4'd0;
                dp_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        seg_c = enc(nib);
`ifdef HOUR_LZB_EN
        // Blank only the segments; the anode stays lit so duty is unchanged.
        if (idx == 3'd5 && nib == 4'd0) seg_c = 7'h00;
`endif
        an_c = disp_en ? (6'b000001 << idx) : 6'b000000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler    <= '0;
            idx          <= 3'd0;
            load_pending <= 1'b1;
            sh_pm        <= 1'b0;
            sh_hh        <= 8'h12;
            sh_mm        <= 8'h00;
            sh_ss        <= 8'h00;
            bcd_err      <= 1'b0;
            seg          <= SEG_INV;
            dp           <= DP_INV;
            an           <= AN_INV;
        end else begin
            prescaler    <= tick ? '0 : prescaler + PW'(1);
            load_pending <= 1'b0;
            if (tick) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            if (snap) begin
                sh_pm <= pm;
                sh_hh <= hh;
                sh_mm <= mm;
                sh_ss <= ss;
                if (in_err) bcd_err <= 1'b1;
            end
            seg <= seg_c ^ SEG_INV;
            dp  <= dp_c ^ DP_INV;
            an  <= an_c ^ AN_INV;
        end
    end

endmodule

// File: tb/tb_bcd_time_display_scan.sv
// tb_bcd_time_display_scan: directed checks of the BCD scan display.
// SCAN_DIV=4, active-high outputs.

module tb_bcd_time_display_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic       disp_en;
    logic       pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       bcd_err;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    bcd_time_display_scan #(
        .SCAN_DIV      (4),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .disp_en(disp_en),
        .pm     (pm),
        .hh     (hh),
        .mm     (mm),
        .ss     (ss),
        .seg    (seg),
        .dp     (dp),
        .an     (an),
        .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Advance to just after edge number t (counted from reset release).
    task automatic goto(input int t);
        while (k < t) begin
            @(posedge clk);
            k++;
        end
        #1;
    endtask

    logic [6:0] segx [6];
    logic       dpx  [6];
    logic [6:0] hz;

    initial begin
        segx = '{7'h7F, 7'h6D, 7'h6F, 7'h6D, 7'h06, 7'h06};
        dpx  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef HOUR_LZB_EN
        hz = 7'h00;
`else
        hz = 7'h3F;
`endif

        reset   = 1'b1;
        disp_en = 1'b1;
        pm      = 1'b1;
        hh      = 8'h11;
        mm      = 8'h59;
        ss      = 8'h58;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'h0);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_err", 32'(bcd_err), 32'h0);
        reset = 1'b0;
        k     = 0;

        // 11:59:58 PM, one full frame
        for (int i = 0; i < 6; i++) begin
            goto(4 * i + 2);
            check("f0_an", 32'(an), 32'(6'b000001 << i));
            check("f0_seg", 32'(seg), 32'(segx[i]));
            check("f0_dp", 32'(dp), 32'(dpx[i]));
        end
        goto(23);
        check("f0_err", 32'(bcd_err), 32'h0);

        // Mid-frame input change must wait for the next frame
        goto(26);
        check("f1_idx0", 32'(seg), 32'h7F);
        goto(38);
        ss = 8'h59;
        goto(46);
        check("f1_idx5", 32'(seg), 32'h06);
        goto(50);
        check("f2_idx0", 32'(seg), 32'h6F);

        // Malformed seconds units
        ss = 8'h5A;
        goto(71);
        check("err_pre", 32'(bcd_err), 32'h0);
        goto(74);
        check("dash", 32'(seg), 32'h40);
        check("err_set", 32'(bcd_err), 32'h1);
        ss = 8'h30;
        goto(98);
        check("fix_seg", 32'(seg), 32'h3F);
        check("err_stk", 32'(bcd_err), 32'h1);

        // Display disable for 10 clocks starting at idx2
        goto(105);
        check("en_an", 32'(an), 32'h04);
        disp_en = 1'b0;
        goto(106);
        check("dis_an0", 32'(an), 32'h0);
        goto(110);
        check("dis_an1", 32'(an), 32'h0);
        goto(115);
        check("dis_an2", 32'(an), 32'h0);
        disp_en = 1'b1;
        goto(116);
        check("reen_an", 32'(an), 32'h10);

        // Reset at idx3, prescaler 1
        goto(133);
        pm    = 1'b0;
        hh    = 8'h03;
        mm    = 8'h07;
        ss    = 8'h09;
        reset = 1'b1;
        goto(134);
        check("mrst_an", 32'(an), 32'h0);
        check("mrst_seg", 32'(seg), 32'h0);
        check("mrst_err", 32'(bcd_err), 32'h0);
        reset = 1'b0;
        k     = 0;
        goto(2);
        check("r_an", 32'(an), 32'h01);
        check("r_seg0", 32'(seg), 32'h6F);
        check("r_dp0", 32'(dp), 32'h0);
        goto(10);
        check("r_seg2", 32'(seg), 32'h07);
        check("r_dp2", 32'(dp), 32'h1);

        // Hours tens zero, then out-of-range hours
        goto(22);
        check("hz_an", 32'(an), 32'h20);
        check("hz_seg", 32'(seg), 32'(hz));
        hh = 8'h13;
        goto(23);
        check("h13_pre", 32'(bcd_err), 32'h0);
        goto(25);
        check("h13_err", 32'(bcd_err), 32'h1);
        goto(42);
        check("h13_seg4", 32'(seg), 32'h4F);
        goto(46);
        check("h13_seg5", 32'(seg), 32'h06);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
